// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V platform constants: imem loader FSM states and stream format
package riscv_pkg;

   // Loader FSM state encoding
   typedef logic [2:0] imem_ld_state_t;

   localparam imem_ld_state_t ST_CNT_LO = 3'd0;
   localparam imem_ld_state_t ST_CNT_HI = 3'd1;
   localparam imem_ld_state_t ST_DATA   = 3'd2;
   localparam imem_ld_state_t ST_CSUM   = 3'd3;
   localparam imem_ld_state_t ST_DONE   = 3'd4;
   localparam imem_ld_state_t ST_ERROR  = 3'd5;

   // Stream format: 2 count bytes, little-endian 4-byte words, one 8-bit checksum byte
   localparam int unsigned HDR_LEN        = 2;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned CSUM_W         = 8;
   localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction-memory write bundle
interface imem_loader_if;

   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   // Stream source / memory sink side
   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

   // Loader side
   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

endinterface

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - assembles little-endian bytes into words and times the write strobe
module imem_byte_packer
   import riscv_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_last,
   output logic        o_we,
   output logic [31:0] o_wdata
);

   logic [BYTE_IDX_W-1:0] r_idx;
   logic [23:0]           r_low;
   logic                  r_we;
   logic [31:0]           r_wdata;
   logic                  w_last;

   // The accepted byte is the top byte of the current word
   assign w_last = i_byte_valid && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

   // Lower three bytes shift in from the top so byte 0 ends up in bits 7:0;
   // the strobe is registered so it lands on the cycle after the 4th byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx   <= '0;
         r_low   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (i_clear) begin
         r_idx   <= '0;
         r_low   <= '0;
         r_we    <= 1'b0;
      end else begin
         r_we <= w_last;
         if (i_byte_valid) begin
            r_idx <= r_idx + BYTE_IDX_W'(1);
            if (w_last) begin
               r_wdata <= {i_byte, r_low};
            end else begin
               r_low <= {i_byte, r_low[23:8]};
            end
         end
      end
   end

   assign o_word_last = w_last;
   assign o_we        = r_we;
   assign o_wdata     = r_wdata;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a counted, checksummed byte stream into instruction memory
module imem_loader
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
   input  logic         CLK,
   input  logic         rst,
   input  logic         reload,
   imem_loader_if.slave bus,
   output logic         core_rst,
   output logic         done,
   output logic         err
);

   imem_ld_state_t    r_state;
   logic [15:0]       r_count;
   logic [15:0]       r_words;
   logic [CSUM_W-1:0] r_csum;
   logic [31:0]       r_addr;

   logic        w_active;
   logic        w_accept;
   logic        w_data_byte;
   logic        w_word_last;
   logic        w_pack_we;
   logic [31:0] w_pack_wdata;
   logic [15:0] w_n;

   // Bytes flow only while a session is still open; reload swallows the byte
   assign w_active    = (r_state != ST_DONE) && (r_state != ST_ERROR);
   assign w_accept    = bus.in_valid && w_active && !reload;
   assign w_data_byte = w_accept && (r_state == ST_DATA);
   assign w_n         = {bus.in_data, r_count[7:0]};

   imem_byte_packer u_packer (
      .i_clk        (CLK),
      .i_rst        (rst),
      .i_clear      (reload),
      .i_byte_valid (w_data_byte),
      .i_byte       (bus.in_data),
      .o_word_last  (w_word_last),
      .o_we         (w_pack_we),
      .o_wdata      (w_pack_wdata)
   );

   // Session FSM: header parse, word counting, running checksum and final verdict
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_state <= ST_CNT_LO;
         r_count <= '0;
         r_words <= '0;
         r_csum  <= '0;
      end else if (reload) begin
         r_state <= ST_CNT_LO;
         r_count <= '0;
         r_words <= '0;
         r_csum  <= '0;
      end else if (w_accept) begin
         case (r_state)
            ST_CNT_LO: begin
               r_count[7:0] <= bus.in_data;
               r_state      <= ST_CNT_HI;
            end
            ST_CNT_HI: begin
               r_count <= w_n;
               if (32'(w_n) > DEPTH) begin
                  r_state <= ST_ERROR;
               end else if (w_n == 16'd0) begin
                  r_state <= ST_CSUM;
               end else begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_csum <= r_csum + bus.in_data;
               if (w_word_last) begin
                  r_words <= r_words + 16'd1;
                  if (r_words == r_count - 16'd1) begin
                     r_state <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               r_state <= (bus.in_data == r_csum) ? ST_DONE : ST_ERROR;
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   // Write address advances once each strobe has gone out; reload rewinds it
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_addr <= BASE_ADDR;
      end else if (reload) begin
         r_addr <= BASE_ADDR;
      end else if (w_pack_we) begin
         r_addr <= r_addr + 32'(BYTES_PER_WORD);
      end
   end

   assign bus.in_ready   = w_active;
   assign bus.imem_we    = w_pack_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = w_pack_wdata;

   assign core_rst = (r_state != ST_DONE);
   assign done     = (r_state == ST_DONE);
   assign err      = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a stream-level model
module tb_imem_loader;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic CLK      = 1'b0;
   logic rst      = 1'b1;
   logic reload   = 1'b0;
   logic core_rst;
   logic done;
   logic err;

   imem_loader_if bus ();

   imem_loader #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .CLK      (CLK),
      .rst      (rst),
      .reload   (reload),
      .bus      (bus),
      .core_rst (core_rst),
      .done     (done),
      .err      (err)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the bytes accepted in the current session decide everything
   logic [7:0]  sess[$];
   logic        exp_we   = 1'b0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic [31:0] dut_addr_q[$];
   logic [31:0] dut_data_q[$];

   // 0 = still loading, 1 = good load, 2 = failed load
   function automatic int model_status();
      int n;
      int need;
      logic [7:0] s;
      if (sess.size() < 2) return 0;
      n = int'({sess[1], sess[0]});
      if (n > int'(DEPTH)) return 2;
      need = 2 + 4 * n + 1;
      if (sess.size() < need) return 0;
      s = 8'h00;
      for (int i = 2; i < need - 1; i++) s = s + sess[i];
      return (s == sess[need - 1]) ? 1 : 2;
   endfunction

   always @(posedge CLK) begin
      int p;
      int n;
      if (rst) begin
         sess.delete();
         exp_we = 1'b0;
      end else begin
         exp_we = 1'b0;
         if (reload) begin
            sess.delete();
         end else if (bus.in_valid && model_status() == 0) begin
            sess.push_back(bus.in_data);
            p = sess.size() - 1;
            if (p >= 2) begin
               n = int'({sess[1], sess[0]});
               if ((p - 2) < 4 * n && (p - 2) % 4 == 3) begin
                  exp_we   = 1'b1;
                  exp_addr = BASE + 32'(4 * ((p - 2) / 4));
                  exp_data = {sess[p], sess[p-1], sess[p-2], sess[p-3]};
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      int st;
      if (!rst) begin
         st = model_status();
         check("in_ready", 32'(bus.in_ready), 32'(st == 0));
         check("done", 32'(done), 32'(st == 1));
         check("err", 32'(err), 32'(st == 2));
         check("core_rst", 32'(core_rst), 32'(st != 1));
         check("imem_we", 32'(bus.imem_we), 32'(exp_we));
         if (exp_we) begin
            check("imem_addr", bus.imem_addr, exp_addr);
            check("imem_wdata", bus.imem_wdata, exp_data);
         end
         if (bus.imem_we === 1'b1) begin
            dut_addr_q.push_back(bus.imem_addr);
            dut_data_q.push_back(bus.imem_wdata);
         end
      end
   end

   // Stimulus helpers: inputs change 1 time unit after the rising edge
   logic [7:0] stim[$];

   task automatic cyc(input logic v, input logic [7:0] d, input logic rl);
      bus.in_valid = v;
      bus.in_data  = d;
      reload       = rl;
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      reload       = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      int k;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 20) begin
         cyc(1'b0, 8'h00, 1'b0);
         k++;
      end
      if (bus.in_ready !== 1'b1) check("send_ready", 32'(bus.in_ready), 32'd1);
      cyc(1'b1, d, 1'b0);
   endtask

   task automatic send_stim(input int gap);
      foreach (stim[i]) begin
         send(stim[i]);
         repeat (gap) cyc(1'b0, 8'hFF, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00, 1'b0);
   endtask

   // Data bytes sum to 0x8B modulo 256
   task automatic load_stream(input logic [7:0] csum);
      stim = '{8'h02, 8'h00, 8'h33, 8'h81, 8'h11, 8'h40, 8'h33, 8'h22, 8'h31, 8'h00, csum};
   endtask

   task automatic check_two_writes(input string tag, input int base_idx);
      check({tag, "_addr0"}, dut_addr_q[base_idx],     32'h0000_0000);
      check({tag, "_data0"}, dut_data_q[base_idx],     32'h4011_8133);
      check({tag, "_addr1"}, dut_addr_q[base_idx + 1], 32'h0000_0004);
      check({tag, "_data1"}, dut_data_q[base_idx + 1], 32'h0031_2233);
   endtask

   task automatic new_session();
      cyc(1'b0, 8'h00, 1'b1);
      dut_addr_q.delete();
      dut_data_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_imem_we", 32'(bus.imem_we), 32'd0);
      check("rst_imem_addr", bus.imem_addr, BASE);
      check("rst_imem_wdata", bus.imem_wdata, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      idle(2);

      // Good load, then bytes offered in DONE are refused
      load_stream(8'h8B);
      send_stim(0);
      idle(2);
      check("good_nwrites", 32'(dut_addr_q.size()), 32'd2);
      check_two_writes("good", 0);
      check("good_done", 32'(done), 32'd1);
      check("good_core_rst", 32'(core_rst), 32'd0);
      repeat (3) cyc(1'b1, 8'hAA, 1'b0);
      check("done_hold", 32'(done), 32'd1);

      // Bad checksum
      new_session();
      load_stream(8'h8C);
      send_stim(0);
      idle(2);
      check("bad_nwrites", 32'(dut_addr_q.size()), 32'd2);
      check_two_writes("bad", 0);
      check("bad_err", 32'(err), 32'd1);
      check("bad_core_rst", 32'(core_rst), 32'd1);
      check("bad_in_ready", 32'(bus.in_ready), 32'd0);

      // Oversized count: error after the count bytes, no writes
      new_session();
      send(8'h41);
      send(8'h00);
      check("big_err", 32'(err), 32'd1);
      repeat (5) cyc(1'b1, 8'h33, 1'b0);
      check("big_nwrites", 32'(dut_addr_q.size()), 32'd0);

      // Empty image
      new_session();
      stim = '{8'h00, 8'h00, 8'h00};
      send_stim(0);
      idle(1);
      check("zero_done", 32'(done), 32'd1);
      check("zero_nwrites", 32'(dut_addr_q.size()), 32'd0);

      // Valid toggled every other cycle
      new_session();
      load_stream(8'h8B);
      send_stim(1);
      idle(2);
      check("tog_nwrites", 32'(dut_addr_q.size()), 32'd2);
      check_two_writes("tog", 0);
      check("tog_done", 32'(done), 32'd1);

      // Reload right after a word (pending strobe still issues), then after the 5th data byte
      new_session();
      stim = '{8'h02, 8'h00, 8'h33, 8'h81, 8'h11, 8'h40};
      send_stim(0);
      cyc(1'b1, 8'h33, 1'b1);
      stim = '{8'h02, 8'h00, 8'h33, 8'h81, 8'h11, 8'h40, 8'h33};
      send_stim(0);
      idle(1);
      cyc(1'b1, 8'h22, 1'b1);
      load_stream(8'h8B);
      send_stim(0);
      idle(2);
      check("rl_nwrites", 32'(dut_addr_q.size()), 32'd4);
      check("rl_addr_a", dut_addr_q[0], 32'h0000_0000);
      check("rl_addr_b", dut_addr_q[1], 32'h0000_0000);
      check_two_writes("rl", 2);
      check("rl_done", 32'(done), 32'd1);

      // Reload colliding with a word's 4th byte and with the checksum byte
      new_session();
      stim = '{8'h02, 8'h00, 8'h33, 8'h81, 8'h11};
      send_stim(0);
      cyc(1'b1, 8'h40, 1'b1);
      idle(2);
      check("col_word_nwrites", 32'(dut_addr_q.size()), 32'd0);
      stim = '{8'h02, 8'h00, 8'h33, 8'h81, 8'h11, 8'h40, 8'h33, 8'h22, 8'h31, 8'h00};
      send_stim(0);
      cyc(1'b1, 8'h8B, 1'b1);
      idle(2);
      check("col_csum_done", 32'(done), 32'd0);
      check("col_csum_ready", 32'(bus.in_ready), 32'd1);
      load_stream(8'h8B);
      send_stim(0);
      idle(2);
      check("col_nwrites", 32'(dut_addr_q.size()), 32'd4);
      check_two_writes("col", 2);
      check("col_done", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
